// File: rtl/exe_stage.sv
// EXE pipeline stage: ALU, data-SRAM request issue, store data/strobe formatting, forwarding.
// Optional misaligned-access detection is enabled by defining EXE_ALE_CHECK_EN.
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [147:0] ds_to_es_bus,
    output logic         es_to_ms_valid,
    output logic [77:0]  es_to_ms_bus,
    output logic         data_sram_req,
    output logic         data_sram_wr,
    output logic [1:0]   data_sram_size,
    output logic [3:0]   data_sram_wstrb,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    input  logic         data_sram_addr_ok,
    input  logic         mem_ex,
    input  logic         wb_ex,
    input  logic         wb_ertn,
    output logic         es_fwd_valid,
    output logic [4:0]   es_fwd_dest,
    output logic [31:0]  es_fwd_data,
    output logic         es_load_pending
);
    logic         es_valid_q, es_valid_d;
    logic         req_sent_q, req_sent_d;
    logic [147:0] es_bus_q, es_bus_d;

    logic        ds_ex, gr_we, res_from_mem;
    logic [4:0]  dest, ld_op;
    logic [2:0]  st_op;
    logic [3:0]  alu_op;
    logic [31:0] rkd_value, alu_src2, alu_src1, es_pc;

    assign {ds_ex, dest, gr_we, res_from_mem, st_op, ld_op, rkd_value,
            alu_op, alu_src2, alu_src1, es_pc} = es_bus_q;

    logic [31:0] alu_result, mem_addr;
    logic        mem_op, byte_op, half_op, ale, es_ex, flush, es_ready_go;

    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            4'd0: alu_result = alu_src1 + alu_src2;
            4'd1: alu_result = alu_src1 - alu_src2;
            4'd2: alu_result = alu_src1 & alu_src2;
            4'd3: alu_result = alu_src1 | alu_src2;
            4'd4: alu_result = alu_src1 ^ alu_src2;
            4'd5: alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
            4'd6: alu_result = {31'd0, alu_src1 < alu_src2};
            4'd7: alu_result = alu_src2;
            default: alu_result = 32'd0;
        endcase
    end

    // Memory address is always the adder output, independent of alu_op.
    assign mem_addr = alu_src1 + alu_src2;
    assign mem_op   = |ld_op || |st_op;
    assign byte_op  = ld_op[4] | ld_op[3] | st_op[2];
    assign half_op  = ld_op[2] | ld_op[1] | st_op[1];

`ifdef EXE_ALE_CHECK_EN
    logic word_op;
    assign word_op = ld_op[0] | st_op[0];
    assign ale     = (half_op & mem_addr[0]) | (word_op & (mem_addr[1:0] != 2'b00));
`else
    assign ale = 1'b0;
`endif

    assign es_ex = ds_ex | ale;
    assign flush = wb_ex | wb_ertn;

    assign data_sram_req  = es_valid_q && mem_op && !es_ex && !mem_ex && !flush && !req_sent_q;
    assign es_ready_go    = !mem_op || es_ex || req_sent_q || (data_sram_req && data_sram_addr_ok);
    assign es_allowin     = !es_valid_q || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid_q && es_ready_go && !flush;

    assign es_to_ms_bus = {mem_op && !es_ex, ale, ld_op, res_from_mem, gr_we, dest, alu_result, es_pc};

    assign data_sram_wr   = |st_op;
    assign data_sram_size = byte_op ? 2'd0 : half_op ? 2'd1 : mem_op ? 2'd2 : 2'd0;
    assign data_sram_addr = mem_addr;

    always_comb begin
        data_sram_wdata = rkd_value;
        data_sram_wstrb = 4'b0000;
        if (st_op[2]) begin
            data_sram_wdata = {4{rkd_value[7:0]}};
            data_sram_wstrb = 4'b0001 << mem_addr[1:0];
        end else if (st_op[1]) begin
            data_sram_wdata = {2{rkd_value[15:0]}};
            data_sram_wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
        end else if (st_op[0]) begin
            data_sram_wstrb = 4'b1111;
        end
    end

    assign es_fwd_valid    = es_valid_q && gr_we && (dest != 5'd0);
    assign es_fwd_dest     = dest;
    assign es_fwd_data     = alu_result;
    assign es_load_pending = es_valid_q && res_from_mem;

    always_comb begin
        es_valid_d = es_valid_q;
        es_bus_d   = es_bus_q;
        req_sent_d = req_sent_q;
        if (ds_to_es_valid && es_allowin)
            es_bus_d = ds_to_es_bus;
        if (flush)
            es_valid_d = 1'b0;
        else if (es_allowin)
            es_valid_d = ds_to_es_valid;
        // Departure clears before a same-cycle accept could set it.
        if (flush || (es_to_ms_valid && ms_allowin))
            req_sent_d = 1'b0;
        else if (data_sram_req && data_sram_addr_ok)
            req_sent_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            req_sent_q <= 1'b0;
            es_bus_q   <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            req_sent_q <= req_sent_d;
            es_bus_q   <= es_bus_d;
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural stage model.
module tb_exe_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin, es_allowin, ds_to_es_valid, es_to_ms_valid;
    logic [147:0] ds_to_es_bus;
    logic [77:0]  es_to_ms_bus;
    logic         data_sram_req, data_sram_wr, data_sram_addr_ok;
    logic [1:0]   data_sram_size;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    logic         mem_ex, wb_ex, wb_ertn;
    logic         es_fwd_valid, es_load_pending;
    logic [4:0]   es_fwd_dest;
    logic [31:0]  es_fwd_data;

    exe_stage dut (
        .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .mem_ex(mem_ex), .wb_ex(wb_ex),
        .wb_ertn(wb_ertn), .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest),
        .es_fwd_data(es_fwd_data), .es_load_pending(es_load_pending)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [147:0] mk(input logic ex, input logic [4:0] dst, input logic we,
                                        input logic rfm, input logic [2:0] st, input logic [4:0] ld,
                                        input logic [31:0] rkd, input logic [3:0] op,
                                        input logic [31:0] s2, input logic [31:0] s1,
                                        input logic [31:0] pc);
        return {ex, dst, we, rfm, st, ld, rkd, op, s2, s1, pc};
    endfunction

    // Model state: the instruction held in EXE and whether its request was accepted.
    logic         m_valid, m_sent;
    logic [147:0] m_bus;

    typedef struct packed {
        logic        allowin, to_ms, req, wr, memop, store;
        logic [77:0] bus;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr, wdata;
        logic        fwd_valid;
        logic [4:0]  fwd_dest;
        logic [31:0] fwd_data;
        logic        load_pending;
    } exp_t;

    function automatic exp_t model_out();
        exp_t e;
        logic        ex_in, we, rfm, ale, exc, go, flush;
        logic [4:0]  dst, ld;
        logic [2:0]  st;
        logic [3:0]  op;
        logic [31:0] rkd, s1, s2, pc, res, addr;
        int unsigned lo;
        {ex_in, dst, we, rfm, st, ld, rkd, op, s2, s1, pc} = m_bus;
        case (op)
            4'd0: res = s1 + s2;
            4'd1: res = s1 - s2;
            4'd2: res = s1 & s2;
            4'd3: res = s1 | s2;
            4'd4: res = s1 ^ s2;
            4'd5: res = ($signed(s1) < $signed(s2)) ? 32'd1 : 32'd0;
            4'd6: res = (s1 < s2) ? 32'd1 : 32'd0;
            4'd7: res = s2;
            default: res = 32'd0;
        endcase
        addr = s1 + s2;
        lo = addr % 4;
        e = '0;
        e.memop = (ld != 0) || (st != 0);
        e.store = (st != 0);
`ifdef EXE_ALE_CHECK_EN
        ale = ((ld == 5'b00100 || ld == 5'b00010 || st == 3'b010) && (lo % 2 != 0)) ||
              ((ld == 5'b00001 || st == 3'b001) && lo != 0);
`else
        ale = 1'b0;
`endif
        exc   = ex_in || ale;
        flush = wb_ex || wb_ertn;
        e.req = m_valid && e.memop && !exc && !mem_ex && !flush && !m_sent;
        go    = !e.memop || exc || m_sent || (e.req && data_sram_addr_ok);
        e.allowin = !m_valid || (go && ms_allowin);
        e.to_ms   = m_valid && go && !flush;
        e.bus  = {e.memop && !exc, ale, ld, rfm, we, dst, res, pc};
        e.wr   = e.store;
        e.addr = addr;
        if (ld == 5'b10000 || ld == 5'b01000 || st == 3'b100) e.size = 2'd0;
        else if (ld == 5'b00100 || ld == 5'b00010 || st == 3'b010) e.size = 2'd1;
        else e.size = 2'd2;
        case (st)
            3'b100: begin e.wdata = {4{rkd[7:0]}};  e.wstrb = 4'(1 << lo); end
            3'b010: begin e.wdata = {2{rkd[15:0]}}; e.wstrb = (lo >= 2) ? 4'hC : 4'h3; end
            3'b001: begin e.wdata = rkd;            e.wstrb = 4'hF; end
            default: begin e.wdata = rkd;           e.wstrb = 4'h0; end
        endcase
        e.fwd_valid    = m_valid && we && dst != 0;
        e.fwd_dest     = dst;
        e.fwd_data     = res;
        e.load_pending = m_valid && rfm;
        return e;
    endfunction

    // Model advance on every clock edge.
    initial begin
        exp_t em;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_valid = 1'b0; m_sent = 1'b0; m_bus = '0;
            end else begin
                em = model_out();
                if (wb_ex || wb_ertn || (em.to_ms && ms_allowin)) m_sent = 1'b0;
                else if (em.req && data_sram_addr_ok) m_sent = 1'b1;
                if (ds_to_es_valid && em.allowin) m_bus = ds_to_es_bus;
                if (wb_ex || wb_ertn) m_valid = 1'b0;
                else if (em.allowin) m_valid = ds_to_es_valid;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        exp_t ec;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ec = model_out();
                chk("m_allowin", es_allowin, ec.allowin);
                chk("m_to_ms_valid", es_to_ms_valid, ec.to_ms);
                chk("m_to_ms_bus", es_to_ms_bus, ec.bus);
                chk("m_req", data_sram_req, ec.req);
                chk("m_wr", data_sram_wr, ec.wr);
                chk("m_wstrb", data_sram_wstrb, ec.wstrb);
                chk("m_addr", data_sram_addr, ec.addr);
                if (ec.memop) chk("m_size", data_sram_size, ec.size);
                if (ec.store) chk("m_wdata", data_sram_wdata, ec.wdata);
                chk("m_fwd_valid", es_fwd_valid, ec.fwd_valid);
                chk("m_fwd_dest", es_fwd_dest, ec.fwd_dest);
                chk("m_fwd_data", es_fwd_data, ec.fwd_data);
                chk("m_load_pending", es_load_pending, ec.load_pending);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ds_to_es_valid = 1'b0; ms_allowin = 1'b1; data_sram_addr_ok = 1'b0;
        mem_ex = 1'b0; wb_ex = 1'b0; wb_ertn = 1'b0;
    endtask

    function automatic logic [147:0] rnd_inst();
        logic [2:0] st;
        logic [4:0] ld;
        logic [3:0] op;
        int k;
        k  = $urandom_range(0, 3);
        st = 3'b000; ld = 5'b00000;
        op = 4'($urandom_range(0, 9));
        if (k == 1) begin ld = 5'(1 << $urandom_range(0, 4)); op = 4'd0; end
        if (k == 2) begin st = 3'(1 << $urandom_range(0, 2)); op = 4'd0; end
        return mk(($urandom % 16) == 0, 5'($urandom), 1'($urandom), k == 1, st, ld,
                  $urandom, op, $urandom, $urandom, $urandom);
    endfunction

    initial begin
        reset = 1'b1;
        ds_to_es_bus = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_allowin", es_allowin, 1'b1);
        chk("rst_to_ms_valid", es_to_ms_valid, 1'b0);
        chk("rst_bus", es_to_ms_bus, 78'd0);
        chk("rst_req", data_sram_req, 1'b0);
        chk("rst_wr", data_sram_wr, 1'b0);
        chk("rst_size", data_sram_size, 2'd0);
        chk("rst_wstrb", data_sram_wstrb, 4'd0);
        chk("rst_addr", data_sram_addr, 32'd0);
        chk("rst_wdata", data_sram_wdata, 32'd0);
        chk("rst_fwd", {es_fwd_valid, es_fwd_dest, es_fwd_data}, 38'd0);
        chk("rst_load_pending", es_load_pending, 1'b0);
        step();
        reset = 1'b0;

        // ld.w at 0x1000+4, addr_ok arrives in the third cycle
        ds_to_es_bus = mk(0, 5'd3, 1, 1, 3'b000, 5'b00001, 32'd0, 4'd0, 32'd4, 32'h1000, 32'h100);
        ds_to_es_valid = 1'b1;
        step();
        ds_to_es_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) data_sram_addr_ok = 1'b1;
            @(negedge clk);
            chk("ldw_req", data_sram_req, 1'b1);
            chk("ldw_addr", data_sram_addr, 32'h1004);
            chk("ldw_size", data_sram_size, 2'd2);
            chk("ldw_wr", data_sram_wr, 1'b0);
            chk("ldw_to_ms", es_to_ms_valid, c == 3);
            step();
        end
        data_sram_addr_ok = 1'b0;
        @(negedge clk);
        chk("ldw_gone", {es_to_ms_valid, data_sram_req, es_allowin}, 3'b001);

        // st.b at 0x2003, accepted immediately
        ds_to_es_bus = mk(0, 5'd0, 0, 0, 3'b100, 5'b00000, 32'hAB, 4'd0, 32'd0, 32'h2003, 32'h104);
        ds_to_es_valid = 1'b1; data_sram_addr_ok = 1'b1;
        step();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        chk("stb_req", data_sram_req, 1'b1);
        chk("stb_wstrb", data_sram_wstrb, 4'b1000);
        chk("stb_wdata", data_sram_wdata, 32'hABABABAB);
        chk("stb_wr_size", {data_sram_wr, data_sram_size}, 3'b100);
        chk("stb_to_ms", es_to_ms_valid, 1'b1);
        step();
        @(negedge clk);
        chk("stb_gone", es_to_ms_valid, 1'b0);

        // st.w at misaligned 0x2002
        ds_to_es_bus = mk(0, 5'd0, 0, 0, 3'b001, 5'b00000, 32'h1234, 4'd0, 32'd2, 32'h2000, 32'h108);
        ds_to_es_valid = 1'b1;
        step();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
`ifdef EXE_ALE_CHECK_EN
        chk("stw_ale_req", data_sram_req, 1'b0);
        chk("stw_ale_bits", es_to_ms_bus[77:76], 2'b01);
`else
        chk("stw_ale_req", data_sram_req, 1'b1);
        chk("stw_ale_bits", es_to_ms_bus[77:76], 2'b10);
`endif
        chk("stw_ale_to_ms", es_to_ms_valid, 1'b1);
        step();
        data_sram_addr_ok = 1'b0;

        // wb_ex flushes a pending load
        ds_to_es_bus = mk(0, 5'd4, 1, 1, 3'b000, 5'b00001, 32'd0, 4'd0, 32'd0, 32'h3000, 32'h10C);
        ds_to_es_valid = 1'b1;
        step();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        chk("flush_req_before", data_sram_req, 1'b1);
        step();
        wb_ex = 1'b1;
        #1;
        chk("flush_req_drop", {data_sram_req, es_to_ms_valid}, 2'b00);
        step();
        wb_ex = 1'b0;
        @(negedge clk);
        chk("flush_after", {es_to_ms_valid, data_sram_req, es_allowin, es_load_pending}, 4'b0010);

        // mem_ex holds off a store for two cycles
        ds_to_es_bus = mk(0, 5'd0, 0, 0, 3'b001, 5'b00000, 32'h55, 4'd0, 32'd0, 32'h4000, 32'h110);
        ds_to_es_valid = 1'b1; data_sram_addr_ok = 1'b1;
        step();
        ds_to_es_valid = 1'b0; mem_ex = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("memex_stall", {data_sram_req, es_to_ms_valid, es_allowin}, 3'b000);
            step();
        end
        mem_ex = 1'b0;
        @(negedge clk);
        chk("memex_release", {data_sram_req, es_to_ms_valid}, 2'b11);
        step();
        data_sram_addr_ok = 1'b0;

        // add wraps to 0 while MEM back-pressures; bus must hold
        ds_to_es_bus = mk(0, 5'd5, 1, 0, 3'b000, 5'b00000, 32'd0, 4'd0, 32'd1, 32'hFFFFFFFF, 32'h114);
        ds_to_es_valid = 1'b1;
        step();
        ds_to_es_bus = mk(0, 5'd6, 1, 0, 3'b000, 5'b00000, 32'd0, 4'd1, 32'd7, 32'd9, 32'hDEAD);
        ms_allowin = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("bp_result", es_to_ms_bus[63:32], 32'd0);
            chk("bp_pc", es_to_ms_bus[31:0], 32'h114);
            chk("bp_allowin", {es_allowin, es_to_ms_valid}, 2'b01);
            chk("bp_fwd", {es_fwd_valid, es_fwd_dest, es_fwd_data}, {1'b1, 5'd5, 32'd0});
            step();
        end
        ms_allowin = 1'b1; ds_to_es_valid = 1'b0;
        @(negedge clk);
        chk("bp_release", es_allowin, 1'b1);
        step();

        // asynchronous reset mid-handshake
        ds_to_es_bus = mk(0, 5'd7, 1, 1, 3'b000, 5'b00001, 32'd0, 4'd0, 32'd0, 32'h5000, 32'h118);
        ds_to_es_valid = 1'b1;
        step();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        chk("arst_req_before", data_sram_req, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("arst_req_drop", {data_sram_req, es_to_ms_valid, es_allowin}, 3'b001);
        chk("arst_bus", es_to_ms_bus, 78'd0);
        step();
        reset = 1'b0;

        // randomized traffic, checked by the compare process
        for (int n = 0; n < 3000; n++) begin
            ds_to_es_valid    = ($urandom % 4) != 0;
            ds_to_es_bus      = rnd_inst();
            ms_allowin        = ($urandom % 4) != 0;
            data_sram_addr_ok = ($urandom % 3) != 0;
            mem_ex            = ($urandom % 8) == 0;
            wb_ex             = ($urandom % 32) == 0;
            wb_ertn           = ($urandom % 32) == 0;
            step();
        end
        idle_inputs();
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high; ports are named clk and reset.
REQ-002 SHALL provide these ports (direction, width, meaning):
- clk in 1: clock.
- reset in 1: async active-high reset.
- ms_allowin in 1: MEM stage accepts.
- es_allowin out 1: this stage accepts.
- ds_to_es_valid in 1: ID stage has an instruction.
- ds_to_es_bus in 148: instruction from ID, MSB to LSB: {ds_ex[1], dest[5], gr_we[1], res_from_mem[1], st_op[3](b,h,w), ld_op[5](b,bu,h,hu,w), rkd_value[32], alu_op[4], alu_src2[32], alu_src1[32], pc[32]}.
- es_to_ms_valid out 1: instruction offered to MEM.
- es_to_ms_bus out 78: MSB to LSB {is_req[1], ale[1], ld_op[5], res_from_mem[1], gr_we[1], dest[5], alu_result[32], pc[32]}.
- data_sram_req out 1: memory request.
- data_sram_wr out 1: 1 = store.
- data_sram_size out 2: 0 = byte, 1 = half, 2 = word.
- data_sram_wstrb out 4: byte enables.
- data_sram_addr out 32: request address.
- data_sram_wdata out 32: store data.
- data_sram_addr_ok in 1: request accepted.
- mem_ex in 1: MEM stage holds an exception or ertn.
- wb_ex in 1: flush from WB (exception).
- wb_ertn in 1: flush from WB (ertn).
- es_fwd_valid out 1: forwarding data is valid.
- es_fwd_dest out 5: forwarding destination register.
- es_fwd_data out 32: forwarding data (alu_result).
- es_load_pending out 1: es_valid && res_from_mem, for load-use stall in ID.

Function
REQ-003 SHALL latch ds_to_es_bus into es_bus_r when ds_to_es_valid && es_allowin; es_valid <= ds_to_es_valid when es_allowin.
REQ-004 SHALL clear es_valid on the clock edge where wb_ex || wb_ertn; this has priority over the load in REQ-003.
REQ-005 SHALL set es_allowin = !es_valid || (es_ready_go && ms_allowin), and es_to_ms_valid = es_valid && es_ready_go && !(wb_ex || wb_ertn).
REQ-006 SHALL compute alu_result combinationally by alu_op:
- 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt (signed), 6 sltu, 7 pass src2.
- Other codes give 0.
- Results are 32-bit, wrap-around, no overflow trap.
REQ-007 SHALL define mem_op = |ld_op || |st_op; address = alu_src1 + alu_src2 (the add result), regardless of alu_op.
REQ-008 SHALL define es_ex = ds_ex || ale.
REQ-009 SHALL drive data_sram_req = es_valid && mem_op && !es_ex && !mem_ex && !wb_ex && !wb_ertn && !req_sent (combinational).
REQ-010 SHALL set req_sent on a data_sram_req && data_sram_addr_ok edge; SHALL clear req_sent when the instruction leaves the stage (es_to_ms_valid && ms_allowin) or on flush.
REQ-011 SHALL define es_ready_go = !mem_op || es_ex || req_sent || (data_sram_req && data_sram_addr_ok).
- While mem_ex is high with no request sent, the stage stalls; the request issues only after mem_ex drops.
- The stage is flushed by wb_ex/wb_ertn.
REQ-012 SHALL drive is_req = mem_op && !es_ex in es_to_ms_bus; MEM waits for data_ok only when is_req = 1.
REQ-013 SHALL generate store data and strobes (addr[1:0] = a):
- st.b: wdata = {4{rkd[7:0]}}, wstrb = 1<<a.
- st.h: wdata = {2{rkd[15:0]}}, wstrb = a[1] ? 4'b1100 : 4'b0011.
- st.w: wdata = rkd, wstrb = 4'b1111.
- Loads: wstrb = 0.
REQ-014 SHALL set data_sram_wr = |st_op; data_sram_size = 0 for byte ops, 1 for half ops, 2 otherwise; data_sram_addr = full unaligned address.
REQ-015 SHALL drive es_fwd_valid = es_valid && gr_we && dest != 0; es_fwd_dest = dest; es_fwd_data = alu_result.
REQ-016 SHALL hold all outputs stable while stalled (es_valid && !es_ready_go); the bus register does not change.

Reset
REQ-017 SHALL, on reset assertion, asynchronously force es_valid = 0, req_sent = 0, es_bus_r = 0.
- All outputs then read 0 except es_allowin = 1.
- Reset mid-handshake drops data_sram_req immediately.

Configuration
REQ-018 SHALL honour macro EXE_ALE_CHECK_EN.
- Defined: ale = 1 for ld.h/ld.hu/st.h with addr[0] = 1, or ld.w/st.w with addr[1:0] != 0; no request is issued; the stage passes through with es_ready_go = 1.
- Undefined: ale is tied to 0 and every memory op issues a request.

Verification
REQ-019 ld.w, src1 = 0x1000, src2 = 4, addr_ok delayed 3 cycles -> req high 3 cycles with addr 0x1004, size 2, wr 0; es_to_ms_valid in cycle 3; is_req = 1.
REQ-020 st.b, addr 0x2003, rkd = 0x000000AB, addr_ok = 1 -> wstrb 4'b1000, wdata 0xABABABAB, wr 1, one-cycle pass.
REQ-021 With EXE_ALE_CHECK_EN defined, st.w at 0x2002 -> no req, ale = 1, is_req = 0; without the macro -> req issued, ale = 0.
REQ-022 wb_ex asserted while req is pending (addr_ok = 0) -> req drops the same cycle; es_valid = 0 next edge; es_to_ms_valid never asserted.
REQ-023 mem_ex = 1 for 2 cycles with a store in EXE -> no req during those 2 cycles; req in cycle 3.
REQ-024 add, src1 = 0xFFFFFFFF, src2 = 1, ms_allowin = 0 for 2 cycles -> alu_result 0, bus held; es_allowin = 0 until ms_allowin = 1.
